// File: rtl/alu_pkg.sv
// alu_pkg: ALUOp classes, R-type funct codes, ALU control codes and MDU states
package alu_pkg;
    localparam logic [1:0] ALUOP_LS  = 2'b00;
    localparam logic [1:0] ALUOP_BEQ = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_XOR  = 4'b0011;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_SLTU = 4'b1000;
    localparam logic [3:0] CTL_NOR  = 4'b1100;
    localparam logic [3:0] CTL_BAD  = 4'b1111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} mdu_state_t;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one-bit-per-cycle shift-add multiplier / restoring divider on operand magnitudes
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] u, l, d, u_n, l_n, q_f, r_f;
    logic [CW-1:0] cnt;
    logic neg_q, neg_r;
    logic [WIDTH:0] s, t;
    logic [2*WIDTH-1:0] p;
    // u/l form the product (mult) or remainder/quotient (div); outputs are the sign-fixed result after this step
    always_comb begin
        s = {1'b0, u} + (l[0] ? {1'b0, d} : '0);
        t = {u, l[WIDTH-1]} - {1'b0, d};
        u_n = div ? (t[WIDTH] ? {u[WIDTH-2:0], l[WIDTH-1]} : t[WIDTH-1:0]) : s[WIDTH:1];
        l_n = div ? {l[WIDTH-2:0], ~t[WIDTH]} : {s[0], l[WIDTH-1:1]};
        p = neg_q ? -{u_n, l_n} : {u_n, l_n};
        q_f = neg_q ? -l_n : l_n;
        r_f = neg_r ? -u_n : u_n;
        hi_n = div ? r_f : p[2*WIDTH-1:WIDTH];
        lo_n = div ? q_f : p[WIDTH-1:0];
    end
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            u <= '0;
            l <= '0;
            d <= '0;
            cnt <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            u <= '0;
            l <= (sgn & a[WIDTH-1]) ? -a : a;
            d <= (sgn & b[WIDTH-1]) ? -b : b;
            cnt <= '0;
            neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn & a[WIDTH-1];
        end else if (step) begin
            u <= u_n;
            l <= l_n;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: ALU control decode plus multi-cycle multiply/divide sequencer with HI/LO
module alu_mdu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [5:0]         funct,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [3:0]         alu_ctrl_out,
    output logic               busy,
    output logic               done,
    output logic               stall,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    mdu_state_t state, state_n;
    logic r_type, is_mul, is_div, is_mdu, accept, div0, step, last;
    logic [3:0] r_ctl;
    logic [WIDTH-1:0] hi_n, lo_n;
    assign r_type = ALUOp == ALUOP_W'(ALUOP_R);
    assign is_mul = funct == F_MULT || funct == F_MULTU;
    assign is_div = funct == F_DIV || funct == F_DIVU;
    assign is_mdu = is_mul || is_div || funct == F_MFHI || funct == F_MFLO;
    assign accept = start && r_type && (is_mul || is_div) && state == IDLE;
    assign div0 = accept && is_div && op_b == '0;
    assign step = state == MUL || state == DIV;
    assign busy = state != IDLE;
    assign done = state == FIN;
    assign stall = busy && start && r_type && is_mdu;
    always_comb begin
        r_ctl = CTL_BAD;
        case (funct)
            F_ADD:   r_ctl = CTL_ADD;
            F_SUB:   r_ctl = CTL_SUB;
            F_AND:   r_ctl = CTL_AND;
            F_OR:    r_ctl = CTL_OR;
            F_XOR:   r_ctl = CTL_XOR;
            F_NOR:   r_ctl = CTL_NOR;
            F_SLT:   r_ctl = CTL_SLT;
            F_SLTU:  r_ctl = CTL_SLTU;
            default: r_ctl = CTL_BAD;
        endcase
        alu_ctrl_out = ALUOp == ALUOP_W'(ALUOP_LS) ? CTL_ADD :
                       ALUOp == ALUOP_W'(ALUOP_BEQ) ? CTL_SUB :
                       r_type ? r_ctl : CTL_BAD;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !accept ? IDLE : is_mul ? MUL : div0 ? FIN : DIV;
            MUL:     state_n = last ? FIN : MUL;
            DIV:     state_n = last ? FIN : DIV;
            default: state_n = IDLE;
        endcase
    end
    // hi/lo load on the edge entering FIN so they are valid while done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi <= '0;
            lo <= '0;
        end else begin
            state <= state_n;
            if (div0) begin
                hi <= op_a;
                lo <= '1;
            end else if (step && last) begin
                hi <= hi_n;
                lo <= lo_n;
            end
        end
    end
    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .step (step),
        .div  (state == DIV),
        .sgn  (~funct[0]),
        .a    (op_a),
        .b    (op_b),
        .last (last),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );
endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// tb_alu_mdu_ctrl: directed checks of decode, MDU results/latency, stall and reset abort
module tb_alu_mdu_ctrl;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIVS = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] MFLO = 6'b010010, ADD = 6'b100000;
    logic clk = 0, rst = 1, start = 0;
    logic [1:0] ALUOp = 2'b10;
    logic [5:0] funct = ADD;
    logic [31:0] op_a = 0, op_b = 0, hi, lo;
    logic [3:0] alu_ctrl_out;
    logic busy, done, stall;
    int passed = 0, total = 0;
    typedef struct {
        string tag;
        logic [31:0] hi, lo;
        int lat;
    } exp_t;
    exp_t sb[$];
    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] c;
    } dec_t;
    dec_t dec[14] = '{
        '{2'b00, 6'b111111, 4'b0010}, '{2'b01, 6'b100000, 4'b0110},
        '{2'b10, 6'b100000, 4'b0010}, '{2'b10, 6'b100010, 4'b0110},
        '{2'b10, 6'b100100, 4'b0000}, '{2'b10, 6'b100101, 4'b0001},
        '{2'b10, 6'b100110, 4'b0011}, '{2'b10, 6'b100111, 4'b1100},
        '{2'b10, 6'b101010, 4'b0111}, '{2'b10, 6'b101011, 4'b1000},
        '{2'b10, 6'b111111, 4'b1111}, '{2'b10, 6'b011000, 4'b1111},
        '{2'b10, 6'b010010, 4'b1111}, '{2'b11, 6'b100000, 4'b1111}
    };

    alu_mdu_ctrl #(.WIDTH(32), .ALUOP_W(2)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .funct(funct), .start(start),
        .op_a(op_a), .op_b(op_b), .alu_ctrl_out(alu_ctrl_out), .busy(busy),
        .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        logic [63:0] q, r;
        if (f == MULT) return longint'($signed(a)) * longint'($signed(b));
        if (f == MULTU) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (f == DIVS) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = {32'b0, a / b};
            r = {32'b0, a % b};
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_mdu(string tag, logic [5:0] f, logic [31:0] a, logic [31:0] b,
                           logic [31:0] eh, logic [31:0] el, int elat);
        exp_t e;
        int cyc, bcnt;
        sb.push_back('{tag, eh, el, elat});
        @(negedge clk);
        ALUOp = 2'b10;
        funct = f;
        op_a = a;
        op_b = b;
        start = 1;
        @(negedge clk);
        start = 0;
        op_a = ~a;
        op_b = 0;
        cyc = 1;
        bcnt = busy ? 1 : 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
        end
        e = sb.pop_front();
        chk({e.tag, " latency"}, 64'(cyc), 64'(e.lat));
        chk({e.tag, " busy_cycles"}, 64'(bcnt), 64'(e.lat));
        chk({e.tag, " hi"}, {32'b0, hi}, {32'b0, e.hi});
        chk({e.tag, " lo"}, {32'b0, lo}, {32'b0, e.lo});
        @(negedge clk);
        chk({e.tag, " idle"}, {62'b0, busy, done}, 64'b0);
    endtask

    initial begin
        logic [63:0] m;
        logic [31:0] ra, rb;
        logic stall_ok;
        int cyc;
        start = 1;
        funct = MULT;
        repeat (2) @(negedge clk);
        chk("reset_state", {28'b0, busy, done, stall, 1'b0, hi, lo}, 64'b0);
        start = 0;
        rst = 0;
        @(negedge clk);
        chk("reset_wins_start", {63'b0, busy}, 64'b0);
        for (int i = 0; i < 14; i++) begin
            ALUOp = dec[i].op;
            funct = dec[i].f;
            #1;
            chk($sformatf("decode_%0d", i), {60'b0, alu_ctrl_out}, {60'b0, dec[i].c});
        end
        ALUOp = 2'b10;
        run_mdu("mult_neg1x5", MULT, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 32'hFFFFFFFB, 33);
        run_mdu("multu_ffx5", MULTU, 32'hFFFFFFFF, 5, 32'h00000004, 32'hFFFFFFFB, 33);
        run_mdu("div_m7_2", DIVS, -32'sd7, 2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_mdu("divu_100_7", DIVU, 100, 7, 2, 14, 33);
        run_mdu("divu_by0", DIVU, 32'h1234, 0, 32'h1234, 32'hFFFFFFFF, 1);
        run_mdu("div_ovf", DIVS, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 33);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            m = model(MULT + 6'(i), ra, rb);
            run_mdu($sformatf("rand_%0d", i), MULT + 6'(i), ra, rb, m[63:32], m[31:0], 33);
        end
        @(negedge clk);
        funct = MULT;
        op_a = 3;
        op_b = 7;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        funct = ADD;
        start = 1;
        #1;
        chk("add_while_busy_stall", {63'b0, stall}, 64'b0);
        chk("add_while_busy_ctrl", {60'b0, alu_ctrl_out}, 64'h2);
        funct = MFLO;
        #1;
        stall_ok = stall;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            stall_ok &= stall;
            cyc++;
        end
        chk("mflo_stall_until_done", {63'b0, stall_ok}, 64'b1);
        chk("stall_mult_result", {hi, lo}, 64'd21);
        start = 0;
        @(negedge clk);
        funct = DIVS;
        op_a = 1000;
        op_b = 3;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_state", {29'b0, busy, done, stall, hi}, 64'b0);
        chk("abort_lo", {32'b0, lo}, 64'b0);
        rst = 0;
        stall_ok = 1;
        repeat (40) begin
            @(negedge clk);
            stall_ok &= ~done;
        end
        chk("abort_no_done", {63'b0, stall_ok}, 64'b1);
        run_mdu("mult_after_abort", MULT, 32'hFFFFFFF0, 32'h10, 32'hFFFFFFFF, 32'hFFFFFF00, 33);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_mdu_ctrl.md
ALU_MDU_CTRL -- requirements
Module: alu_mdu_ctrl

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits (>=8, even).
REQ-002 Parameter ALUOP_W, 2, ALUOp width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port ALUOp  input  ALUOP_W  main-control op class: 00 load/store, 01 beq, 10 R-type.
REQ-006 Port funct  input  6  R-type function field.
REQ-007 Port start  input  1  qualifies ALUOp/funct/op_a/op_b for one cycle.
REQ-008 Port op_a, op_b  input  WIDTH  rs/rt operand values.
REQ-009 Port alu_ctrl_out  output  4  control code to the combinational ALU.
REQ-010 Port busy  output  1  multiply/divide in progress.
REQ-011 Port done  output  1  one-cycle pulse when hi/lo are updated.
REQ-012 Port stall  output  1  pipeline must hold the current instruction.
REQ-013 Port hi, lo  output  WIDTH  HI/LO registers.

Function
REQ-014 alu_ctrl_out SHALL be combinational from ALUOp/funct: 00->0010, 01->0110; R-type add 100000->0010, sub 100010->0110, and 100100->0000, or 100101->0001, xor 100110->0011, nor 100111->1100, slt 101010->0111, sltu 101011->1000.
REQ-015 Any other ALUOp/funct combination SHALL give alu_ctrl_out=1111 (no latch, no X).
REQ-016 MDU funct codes: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010; alu_ctrl_out=1111 for these.
REQ-017 FSM states IDLE, MUL, DIV, FIN; reset state IDLE.
REQ-018 IDLE: start & ALUOp=10 & mult/multu -> MUL; div/divu with op_b!=0 -> DIV; div/divu with op_b==0 -> FIN; else stay.
REQ-019 Operands SHALL be latched on the accepting edge; later op_a/op_b changes have no effect.
REQ-020 MUL: iterative shift-add, one bit per cycle, exactly WIDTH cycles, then FIN.
REQ-021 DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles, then FIN.
REQ-022 Signed ops SHALL operate on magnitudes; product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-023 Results: mult -> {hi,lo}=2*WIDTH-bit product; div -> lo=quotient, hi=remainder.
REQ-024 Divide by zero: lo=all ones, hi=op_a, FIN reached next cycle.
REQ-025 FIN: hi/lo written, done=1 for exactly that cycle, next state IDLE.
REQ-026 busy SHALL be 1 in MUL, DIV, FIN; 0 in IDLE.
REQ-027 start during busy SHALL be ignored; stall=1 if it carries an MDU funct (mult/div/mfhi/mflo).
REQ-028 stall=0 for non-MDU instructions while busy (independent ALU ops proceed).
REQ-029 Latency start-to-done: WIDTH+1 cycles for mult/div, 1 cycle for div-by-zero.
REQ-030 Signed overflow case (-2^(WIDTH-1) / -1): lo=-2^(WIDTH-1), hi=0, no exception.

Reset
REQ-031 rst SHALL force IDLE, hi=0, lo=0, busy=0, done=0, stall=0, internal accumulators 0.
REQ-032 rst asserted mid-MUL/DIV SHALL abort the operation; no done pulse, hi/lo read 0 next cycle.
REQ-033 rst has priority over start on the same edge.

Structure
REQ-034 ALUOp classes, funct codes and alu_ctrl_out codes SHALL live in shared package alu_pkg, also used by main control.
REQ-035 Decode (REQ-014..016) is combinational in the top; iterative datapath SHALL be sub-module mdu_iter (shift/add/subtract core, count, operand registers).

Verification
REQ-036 WIDTH=32, ALUOp=10, funct=100010 -> alu_ctrl_out=0110; funct=111111 -> 1111.
REQ-037 mult op_a=0xFFFFFFFF (-1), op_b=5 -> busy 33 cycles, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFFB; multu same -> hi=0x00000004, lo=0xFFFFFFFB.
REQ-038 div op_a=-7, op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 100/7 -> lo=14, hi=2.
REQ-039 divu op_a=0x1234, op_b=0 -> done next cycle, lo=0xFFFFFFFF, hi=0x1234.
REQ-040 mflo issued 5 cycles after mult start -> stall=1 until done; add issued same time -> stall=0.
REQ-041 rst asserted 10 cycles into div -> IDLE next cycle, hi=lo=0, no done pulse; new mult then completes normally.
